// File: rtl/instr_queue.sv
// Instruction queue between decode and the backend.
// Decode writes up to ENQ_WIDTH uops per cycle; the valid lanes are packed
// into consecutive entries. The backend sees the DEQ_WIDTH oldest entries
// and says how many it consumed.
// Optional build macro: INSTR_QUEUE_STATS_EN adds the stall and flush
// statistics counters. Without it, both counters read as zero.
// UOP_WIDTH sets the width of one uop_insn payload.
module instr_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ENQ_WIDTH = 4,
    parameter int unsigned DEQ_WIDTH = 4,
    parameter int unsigned UOP_WIDTH = 32
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  flush_in,
    input  logic [ENQ_WIDTH-1:0]                  enq_valid_in,
    input  logic [ENQ_WIDTH-1:0][UOP_WIDTH-1:0]   enq_uop_in,
    output logic                                  enq_ready_out,
    output logic [DEQ_WIDTH-1:0]                  deq_valid_out,
    output logic [DEQ_WIDTH-1:0][UOP_WIDTH-1:0]   deq_uop_out,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]        deq_take_in,
    output logic [$clog2(DEPTH):0]                count_out,
    output logic                                  full_out,
    output logic                                  empty_out,
    output logic [31:0]                           stall_cnt_out,
    output logic [31:0]                           flush_cnt_out
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TAKE_W = $clog2(DEQ_WIDTH + 1);
    localparam int unsigned SUM_W  = CNT_W + TAKE_W;

    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;
    logic [UOP_WIDTH-1:0] mem [DEPTH];

    logic [ENQ_WIDTH-1:0]            wr_en;
    logic [ENQ_WIDTH-1:0][PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0]                wr_off;
    logic [SUM_W-1:0]                enq_cnt;
    logic [SUM_W-1:0]                take_eff;
    logic [SUM_W-1:0]                count_next;

    // Space check from registered count only; lane compaction and pointer math
    always_comb begin
        enq_ready_out = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH);
        wr_en      = '0;
        wr_idx     = '0;
        wr_off     = '0;
        enq_cnt    = '0;
        for (int unsigned l = 0; l < ENQ_WIDTH; l++) begin
            wr_idx[l] = tail_q + wr_off;
            wr_en[l]  = enq_ready_out & enq_valid_in[l];
            if (wr_en[l]) begin
                wr_off  = wr_off + PTR_W'(1);
                enq_cnt = enq_cnt + SUM_W'(1);
            end
        end
        take_eff   = (SUM_W'(deq_take_in) < SUM_W'(count_q)) ? SUM_W'(deq_take_in)
                                                             : SUM_W'(count_q);
        count_next = SUM_W'(count_q) + enq_cnt - take_eff;
    end

    // Pointer and occupancy registers; reset and flush both empty the queue
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(take_eff);
            tail_q  <= tail_q + PTR_W'(enq_cnt);
            count_q <= CNT_W'(count_next);
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk_in) begin
        for (int unsigned l = 0; l < ENQ_WIDTH; l++) begin
            if (wr_en[l]) begin
                mem[wr_idx[l]] <= enq_uop_in[l];
            end
        end
    end

    // Head window and status flags straight from registered state
    always_comb begin
        deq_valid_out = '0;
        deq_uop_out   = '0;
        for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
            deq_valid_out[i] = SUM_W'(i) < SUM_W'(count_q);
            deq_uop_out[i]   = mem[head_q + PTR_W'(i)];
        end
        count_out = count_q;
        full_out  = (count_q == CNT_W'(DEPTH));
        empty_out = (count_q == '0);
    end

`ifdef INSTR_QUEUE_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating statistics; only reset clears them, flush does not
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((|enq_valid_in) && !enq_ready_out && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_in && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_out = stall_cnt_q;
    assign flush_cnt_out = flush_cnt_q;
`else
    assign stall_cnt_out = '0;
    assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue (DEPTH=16, ENQ_WIDTH=4, DEQ_WIDTH=4).
// Stimulus pushes accepted uops into exp_q; a negedge monitor compares the
// head window and flags against exp_q and retires the consumed entries.
module tb_instr_queue;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              flush_in;
    logic [3:0]        enq_valid_in;
    logic [3:0][31:0]  enq_uop_in;
    logic              enq_ready_out;
    logic [3:0]        deq_valid_out;
    logic [3:0][31:0]  deq_uop_out;
    logic [2:0]        deq_take_in;
    logic [4:0]        count_out;
    logic              full_out;
    logic              empty_out;
    logic [31:0]       stall_cnt_out;
    logic [31:0]       flush_cnt_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tag = 32'h1000;

    instr_queue #(.DEPTH(16), .ENQ_WIDTH(4), .DEQ_WIDTH(4), .UOP_WIDTH(32)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .flush_in      (flush_in),
        .enq_valid_in  (enq_valid_in),
        .enq_uop_in    (enq_uop_in),
        .enq_ready_out (enq_ready_out),
        .deq_valid_out (deq_valid_out),
        .deq_uop_out   (deq_uop_out),
        .deq_take_in   (deq_take_in),
        .count_out     (count_out),
        .full_out      (full_out),
        .empty_out     (empty_out),
        .stall_cnt_out (stall_cnt_out),
        .flush_cnt_out (flush_cnt_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][31:0] grp(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [3:0][31:0] next_grp();
        logic [3:0][31:0] g;
        g = grp(tag, tag + 32'd1, tag + 32'd2, tag + 32'd3);
        tag = tag + 32'd4;
        return g;
    endfunction

    // One clock of stimulus; model takes the accepted lanes at the edge
    task automatic step(input logic [3:0] v, input logic [3:0][31:0] u,
                        input logic [2:0] take, input logic fl, input logic rs);
        logic acc;
        enq_valid_in = v;
        enq_uop_in   = u;
        deq_take_in  = take;
        flush_in     = fl;
        rst_in       = rs;
        acc = !rs && !fl && ((16 - exp_q.size()) >= 4);
        @(posedge clk);
        if (rs || fl) begin
            exp_q.delete();
        end else if (acc) begin
            for (int l = 0; l < 4; l++) begin
                if (v[l]) exp_q.push_back(u[l]);
            end
        end
        #1;
    endtask

    // Monitor: compare head window and flags, then retire consumed entries
    always @(negedge clk) begin
        int n;
        int t;
        logic [3:0] ev;
        if (!rst_in) begin
            n = exp_q.size();
            chk("mon_count", 32'(count_out), 32'(n));
            chk("mon_ready", 32'(enq_ready_out), 32'((16 - n) >= 4));
            chk("mon_full",  32'(full_out),  32'(n == 16));
            chk("mon_empty", 32'(empty_out), 32'(n == 0));
            for (int i = 0; i < 4; i++) ev[i] = (i < n);
            chk("mon_valid", 32'(deq_valid_out), 32'(ev));
            for (int i = 0; i < 4; i++) begin
                if (i < n) chk("mon_lane", deq_uop_out[i], exp_q[i]);
            end
            if (!flush_in) begin
                t = (int'(deq_take_in) < n) ? int'(deq_take_in) : n;
                for (int i = 0; i < t; i++) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
        rst_in = 1'b1; flush_in = 1'b0; enq_valid_in = '0; enq_uop_in = '0; deq_take_in = '0;

        // reset state
        step(4'b0000, '0, 3'd0, 1'b0, 1'b1);
        step(4'b1111, next_grp(), 3'd4, 1'b1, 1'b1);
        step(4'b0000, '0, 3'd0, 1'b0, 1'b0);
        chk("rst_ready", 32'(enq_ready_out), 32'd1);
        chk("rst_valid", 32'(deq_valid_out), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_empty", 32'(empty_out), 32'd1);
        chk("rst_full",  32'(full_out), 32'd0);

        // full group A,B,C,D
        step(4'b1111, grp(32'hA, 32'hB, 32'hC, 32'hD), 3'd0, 1'b0, 1'b0);
        chk("abcd_count", 32'(count_out), 32'd4);
        chk("abcd_valid", 32'(deq_valid_out), 32'hF);
        chk("abcd_l0", deq_uop_out[0], 32'hA);
        chk("abcd_l3", deq_uop_out[3], 32'hD);
        step(4'b0000, '0, 3'd4, 1'b0, 1'b0);

        // sparse mask 1010 compacts to X1,X3
        step(4'b1010, grp(32'hF0, 32'hF1, 32'hF2, 32'hF3), 3'd0, 1'b0, 1'b0);
        chk("sparse_count", 32'(count_out), 32'd2);
        chk("sparse_valid", 32'(deq_valid_out), 32'h3);
        chk("sparse_l0", deq_uop_out[0], 32'hF1);
        chk("sparse_l1", deq_uop_out[1], 32'hF3);
        step(4'b0000, '0, 3'd2, 1'b0, 1'b0);

        // fill to 13, then three stalled cycles
        for (int k = 0; k < 3; k++) step(4'b1111, next_grp(), 3'd0, 1'b0, 1'b0);
        step(4'b0001, next_grp(), 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, next_grp(), 3'd0, 1'b0, 1'b0);
            chk("stall_count", 32'(count_out), 32'd13);
            chk("stall_ready", 32'(enq_ready_out), 32'd0);
        end
        step(4'b0000, '0, 3'd1, 1'b0, 1'b0);
        chk("take1_count", 32'(count_out), 32'd12);
        chk("take1_ready", 32'(enq_ready_out), 32'd1);
        step(4'b0000, '0, 3'd4, 1'b0, 1'b0);
        chk("eight_count", 32'(count_out), 32'd8);

        // steady 4-in/4-out across pointer wrap
        for (int k = 0; k < 10; k++) begin
            step(4'b1111, next_grp(), 3'd4, 1'b0, 1'b0);
            chk("steady_count", 32'(count_out), 32'd8);
        end

        // flush beats same-cycle enqueue and take
        step(4'b1111, next_grp(), 3'd4, 1'b1, 1'b0);
        chk("flush_count", 32'(count_out), 32'd0);
        chk("flush_empty", 32'(empty_out), 32'd1);

        // post-flush traffic, take clamped at count
        step(4'b0110, grp(32'hE0, 32'hE1, 32'hE2, 32'hE3), 3'd0, 1'b0, 1'b0);
        step(4'b1001, grp(32'hE4, 32'hE5, 32'hE6, 32'hE7), 3'd1, 1'b0, 1'b0);
        chk("pf_count", 32'(count_out), 32'd3);
        chk("pf_l0", deq_uop_out[0], 32'hE2);
        chk("pf_l2", deq_uop_out[2], 32'hE7);
        step(4'b0000, '0, 3'd4, 1'b0, 1'b0);
        chk("clamp_count", 32'(count_out), 32'd0);

        // fill to full, then drain
        for (int k = 0; k < 4; k++) step(4'b1111, next_grp(), 3'd0, 1'b0, 1'b0);
        chk("full_flag", 32'(full_out), 32'd1);
        chk("full_ready", 32'(enq_ready_out), 32'd0);
        for (int k = 0; k < 4; k++) step(4'b0000, '0, 3'd4, 1'b0, 1'b0);
        chk("drain_empty", 32'(empty_out), 32'd1);

`ifdef INSTR_QUEUE_STATS_EN
        exp_stall = 32'd3;
        exp_flush = 32'd1;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        chk("stall_cnt", stall_cnt_out, exp_stall);
        chk("flush_cnt", flush_cnt_out, exp_flush);

        // mid-operation reset wins over flush and traffic
        step(4'b1111, next_grp(), 3'd0, 1'b0, 1'b0);
        step(4'b1111, next_grp(), 3'd4, 1'b1, 1'b1);
        step(4'b0000, '0, 3'd0, 1'b0, 1'b0);
        chk("mrst_count", 32'(count_out), 32'd0);
        chk("mrst_stall", stall_cnt_out, 32'd0);
        chk("mrst_flush", flush_cnt_out, 32'd0);

        step(4'b0000, '0, 3'd0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning queue entries; power of two, at least ENQ_WIDTH.
REQ-002 SHALL have parameter ENQ_WIDTH, default 4 (SUPER_SCALAR_WIDTH), meaning decode lanes per cycle.
REQ-003 SHALL have parameter DEQ_WIDTH, default 4, meaning backend read lanes per cycle.
REQ-004 SHALL have port clk_in, input, 1, the single clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port flush_in, input, 1, misprediction squash from execute.
REQ-007 SHALL have port enq_valid_in, input, ENQ_WIDTH, per-lane valid mask from decode.
REQ-008 SHALL have port enq_uop_in, input, ENQ_WIDTH x uop_insn, decoded uops, lane 0 oldest.
REQ-009 SHALL have port enq_ready_out, output, 1, queue can accept a full decode group.
REQ-010 SHALL have port deq_valid_out, output, DEQ_WIDTH, head-entry valid mask, thermometer-coded from lane 0.
REQ-011 SHALL have port deq_uop_out, output, DEQ_WIDTH x uop_insn, head entries, lane 0 oldest.
REQ-012 SHALL have port deq_take_in, input, clog2(DEQ_WIDTH+1), number of head entries consumed this cycle.
REQ-013 SHALL have port count_out, output, clog2(DEPTH)+1, occupied entries.
REQ-014 SHALL have ports full_out and empty_out, output, 1 each.
REQ-015 SHALL have ports stall_cnt_out and flush_cnt_out, output, 32 each, statistics (see Configuration).

Function
REQ-016 SHALL keep head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered count.
REQ-017 SHALL drive enq_ready_out = (DEPTH - count) >= ENQ_WIDTH, computed from registered count only; no combinational path from deq_take_in.
REQ-018 SHALL, when enq_ready_out and any enq_valid_in bit are set, write the valid lanes compacted into consecutive entries from tail in ascending lane order, skipping invalid lanes, and advance tail by popcount(enq_valid_in).
REQ-019 SHALL ignore enq_valid_in entirely when enq_ready_out is low; decode holds its group.
REQ-020 SHALL drive deq_uop_out[i] from entry head+i (mod DEPTH) and deq_valid_out[i] = (i < count), purely from registered state.
REQ-021 SHALL clamp the effective take to min(deq_take_in, count) and advance head by the clamped value.
REQ-022 SHALL, on simultaneous enqueue and dequeue, update count_next = count + popcount(accepted) - clamped take.
REQ-023 SHALL give one-cycle latency: a uop enqueued in cycle N appears on deq outputs in cycle N+1 at the earliest.
REQ-024 SHALL preserve program order across pointer wrap-around.
REQ-025 SHALL, on flush_in, zero head, tail and count next cycle; flush overrides any same-cycle enqueue and dequeue.
REQ-026 SHALL drive full_out = (count == DEPTH) and empty_out = (count == 0).

Reset
REQ-027 SHALL on rst_in clear head, tail and count; next cycle enq_ready_out=1, deq_valid_out=0, count_out=0, empty_out=1, full_out=0.
REQ-028 SHALL leave entry storage uninitialised; deq_uop_out is don't-care where deq_valid_out is 0.
REQ-029 SHALL give rst_in priority over flush_in and all traffic, including mid-operation.

Configuration
REQ-030 SHALL, with INSTR_QUEUE_STATS_EN defined, count cycles with any enq_valid_in set and enq_ready_out low into stall_cnt_out, and cycles with flush_in into flush_cnt_out; both saturate at 2^32-1, clear on reset, and are not cleared by flush.
REQ-031 SHALL, without INSTR_QUEUE_STATS_EN, tie stall_cnt_out and flush_cnt_out to 0 and instantiate no counter logic.

Verification (DEPTH=16, ENQ_WIDTH=4, DEQ_WIDTH=4)
REQ-032 SHALL cover: reset, enqueue mask 1111 uops A,B,C,D -> next cycle deq_valid_out=1111, lanes A,B,C,D, count_out=4.
REQ-033 SHALL cover: empty queue, mask 1010 with lanes X0..X3 -> count_out=2, lane0=X1, lane1=X3, deq_valid_out=0011.
REQ-034 SHALL cover: count 13 -> enq_ready_out=0 and enqueue ignored; take 1 -> count 12, enq_ready_out=1 next cycle.
REQ-035 SHALL cover: steady 4-in/4-out for 10 cycles from count 8 -> count stays 8, order intact through wrap.
REQ-036 SHALL cover: flush with enqueue 1111 and take 4 in the same cycle at count 8 -> next cycle count 0, empty_out=1.
REQ-037 SHALL cover: with INSTR_QUEUE_STATS_EN, 3 stalled cycles plus 1 flush -> stall_cnt_out=3, flush_cnt_out=1; without the macro, both 0.
